conv55_window_gen: RTL and testbench



---
 rtl/conv55_window_gen.sv | 113 +++++++++++
 tb/tb_conv55_window_gen.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv55_window_gen.sv
// conv55_window_gen: raster-order pixel stream -> sliding 5x5 window stream.
// Four line buffers supply the four rows above the incoming pixel. A 5x5
// shift register then builds each window, one column per accepted pixel.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
//   - Input side: in_ready = !win_valid || win_ready. A pixel is taken only
//     when the output register is free or is being drained in the same cycle.
//   - Output side: win_valid/win_data/win_last hold stable until win_ready.
module conv55_window_gen #(
    parameter int DATA_W = 6,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_ready,
    output logic                  win_valid,
    output logic [25*DATA_W-1:0]  win_data,
    input  logic                  win_ready,
    output logic                  win_last
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [DATA_W-1:0]     lb0 [IMG_W];
    logic [DATA_W-1:0]     lb1 [IMG_W];
    logic [DATA_W-1:0]     lb2 [IMG_W];
    logic [DATA_W-1:0]     lb3 [IMG_W];
    logic [25*DATA_W-1:0]  win_next;
    logic                  accept;
    logic                  col_end;
    logic                  row_end;
    logic                  emit;

    assign in_ready = !win_valid || win_ready;
    assign accept   = in_valid && in_ready && !clear;
    assign col_end  = (col == CW'(IMG_W - 1));
    assign row_end  = (row == RW'(IMG_H - 1));
    // Only once four full rows and four columns of this row are behind us
    // does the window lie entirely inside the image. This also keeps
    // columns left over from the previous row out of any emitted window.
    assign emit     = (row >= RW'(4)) && (col >= CW'(4));

    // Shift the window left one column; the new column enters at j=4, oldest row on top.
    always_comb begin
        win_next = '0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 4; j++) begin
                win_next[(i*5+j)*DATA_W +: DATA_W] = win_data[(i*5+j+1)*DATA_W +: DATA_W];
            end
        end
        win_next[4*DATA_W  +: DATA_W] = lb3[col];
        win_next[9*DATA_W  +: DATA_W] = lb2[col];
        win_next[14*DATA_W +: DATA_W] = lb1[col];
        win_next[19*DATA_W +: DATA_W] = lb0[col];
        win_next[24*DATA_W +: DATA_W] = in_data;
    end

    // Line buffers age by one row at the current column on every accepted pixel.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb3[col] <= lb2[col];
            lb2[col] <= lb1[col];
            lb1[col] <= lb0[col];
            lb0[col] <= in_data;
        end
    end

    // Raster position counters; wrap at end of row and end of frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Window register and output qualifiers; reloads back-to-back when drained and refilled together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_data  <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else if (clear) begin
            win_data  <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else if (accept) begin
            win_data  <= win_next;
            win_valid <= emit;
            win_last  <= emit && row_end && col_end;
        end else if (win_ready) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv55_window_gen.sv
// Bench for conv55_window_gen on an 8x6 image with pixel(r,c) = r*8+c.
// Every window is checked against a scoreboard built from a copy of the image;
// spot values come from a fixed table of the eight windows in a frame.
module tb_conv55_window_gen;

    localparam int DW = 6;
    localparam int IW = 8;
    localparam int IH = 6;
    localparam int WB = 25 * DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          clear;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          win_valid;
    logic [WB-1:0] win_data;
    logic          win_ready;
    logic          win_last;

    conv55_window_gen #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .win_valid (win_valid),
        .win_data  (win_data),
        .win_ready (win_ready),
        .win_last  (win_last)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- expected window table ----------------
    typedef struct {
        int e0;
        int e4;
        int e20;
        int e24;
        int last;
    } win_vec_t;
    win_vec_t tbl [8];

    // ---------------- scoreboard ----------------
    logic [WB:0]   exp_q [$];
    logic [WB-1:0] cap_data [$];
    logic          cap_last [$];
    logic [DW-1:0] img [IH][IW];
    int mr = 0;
    int mc = 0;

    function automatic int el(input logic [WB-1:0] d, input int k);
        return int'(d[k*DW +: DW]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: records accepted pixels and predicts each window from the image copy.
    always @(posedge clk or negedge rst_n) begin
        logic [WB:0] e;
        if (!rst_n) begin
            mr = 0;
            mc = 0;
            exp_q.delete();
        end else if (clear) begin
            mr = 0;
            mc = 0;
            exp_q.delete();
        end else if (in_valid && in_ready) begin
            img[mr][mc] = in_data;
            if (mr >= 4 && mc >= 4) begin
                e = '0;
                for (int i = 0; i < 5; i++)
                    for (int j = 0; j < 5; j++)
                        e[(i*5+j)*DW +: DW] = img[mr-4+i][mc-4+j];
                e[WB] = (mr == IH-1) && (mc == IW-1);
                exp_q.push_back(e);
            end
            mc++;
            if (mc == IW) begin
                mc = 0;
                mr = (mr == IH-1) ? 0 : mr + 1;
            end
        end
    end

    // Output monitor: pops one expected window per completed output handshake.
    always @(negedge clk) begin
        logic [WB:0] e;
        if (rst_n && win_valid && win_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got window e24=%0d with nothing expected", el(win_data, 24));
            end else begin
                e = exp_q.pop_front();
                if ({win_last, win_data} !== e) begin
                    bad++;
                    $display("FAIL sb_window: got last=%0b e0=%0d e24=%0d expected last=%0b e0=%0d e24=%0d",
                             win_last, el(win_data, 0), el(win_data, 24),
                             e[WB], el(e[WB-1:0], 0), el(e[WB-1:0], 24));
                end
            end
            cap_data.push_back(win_data);
            cap_last.push_back(win_last);
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 just after the pixel was taken.
    task automatic send_pix(input int v);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_data  = DW'(v);
        forever begin
            #1;
            if (in_ready) begin
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            guard++;
            if (guard > 200) begin
                total++;
                bad++;
                $display("FAIL send_timeout: pixel %0d not accepted after %0d cycles", v, guard);
                break;
            end
        end
    endtask

    task automatic send_range(input int first, input int last);
        for (int p = first; p <= last; p++) send_pix(p);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    function automatic int last_count();
        int n;
        n = 0;
        foreach (cap_last[k]) n += int'(cap_last[k]);
        return n;
    endfunction

    task automatic check_table(input string tag);
        for (int k = 0; k < cap_data.size(); k++) begin
            chk($sformatf("%s_e0[%0d]", tag, k),  el(cap_data[k], 0),  tbl[k%8].e0);
            chk($sformatf("%s_e4[%0d]", tag, k),  el(cap_data[k], 4),  tbl[k%8].e4);
            chk($sformatf("%s_e20[%0d]", tag, k), el(cap_data[k], 20), tbl[k%8].e20);
            chk($sformatf("%s_e24[%0d]", tag, k), el(cap_data[k], 24), tbl[k%8].e24);
            chk($sformatf("%s_last[%0d]", tag, k), 32'(cap_last[k]), tbl[k%8].last);
        end
    endtask

    task automatic clear_cap();
        cap_data.delete();
        cap_last.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        // Windows of one frame in emission order: positions (4,4..7) then (5,4..7).
        tbl[0] = '{0,  4,  32, 36, 0};
        tbl[1] = '{1,  5,  33, 37, 0};
        tbl[2] = '{2,  6,  34, 38, 0};
        tbl[3] = '{3,  7,  35, 39, 0};
        tbl[4] = '{8,  12, 40, 44, 0};
        tbl[5] = '{9,  13, 41, 45, 0};
        tbl[6] = '{10, 14, 42, 46, 0};
        tbl[7] = '{11, 15, 43, 47, 1};

        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        win_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_in_ready",  32'(in_ready),  1);
        chk("rst_win_valid", 32'(win_valid), 0);
        chk("rst_win_last",  32'(win_last),  0);
        chk("rst_win_zero",  32'(win_data == '0), 1);
        @(posedge clk); #1;

        // Basic stream: one frame, eight windows.
        clear_cap();
        send_range(0, 47);
        idle(3);
        chk("basic_count", cap_data.size(), 8);
        chk("basic_lasts", last_count(), 1);
        chk("basic_q_empty", exp_q.size(), 0);
        check_table("basic");

        // Backpressure on the first window of the frame.
        clear_cap();
        send_range(0, 36);
        in_data   = DW'(37);
        win_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_in_ready",  32'(in_ready),  0);
            chk("bp_win_valid", 32'(win_valid), 1);
            chk("bp_hold_e24",  el(win_data, 24), 36);
        end
        @(posedge clk); #1;
        win_ready = 1'b1;
        send_range(37, 47);
        idle(3);
        chk("bp_count", cap_data.size(), 8);
        check_table("bp");

        // Row boundary: the first four pixels of row 5 emit nothing.
        clear_cap();
        send_range(0, 39);
        for (int p = 40; p <= 43; p++) begin
            send_pix(p);
            chk($sformatf("rowb_no_win[%0d]", p), 32'(win_valid), 0);
        end
        send_pix(44);
        chk("rowb_valid", 32'(win_valid), 1);
        chk("rowb_e0",    el(win_data, 0),  8);
        chk("rowb_e24",   el(win_data, 24), 44);
        send_range(45, 47);
        idle(3);
        chk("rowb_count", cap_data.size(), 8);

        // Back-to-back frames.
        clear_cap();
        send_range(0, 47);
        send_range(0, 47);
        idle(3);
        chk("b2b_count", cap_data.size(), 16);
        chk("b2b_lasts", last_count(), 2);
        check_table("b2b");

        // Asynchronous reset mid-frame while a window is held.
        send_range(0, 36);
        in_valid  = 1'b0;
        win_ready = 1'b0;
        #1;
        chk("rstmid_pre_valid", 32'(win_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_valid", 32'(win_valid), 0);
        chk("rstmid_zero",  32'(win_data == '0), 1);
        chk("rstmid_ready", 32'(in_ready), 1);
        win_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        clear_cap();
        send_range(0, 47);
        idle(3);
        chk("rstmid_count", cap_data.size(), 8);
        check_table("rstmid");

        // clear with a pixel offered in the same cycle: that pixel is dropped.
        send_range(0, 9);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = DW'(63);
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("clr_in_ready",  32'(in_ready),  1);
        chk("clr_win_valid", 32'(win_valid), 0);
        clear_cap();
        send_range(0, 47);
        idle(3);
        chk("clr_count", cap_data.size(), 8);
        chk("clr_lasts", last_count(), 1);
        check_table("clr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
